// File: rtl/cpt_pkg.sv
// cpt_pkg -- shared types for the cpt_timer_ctrl timer.
//   state_t        : FSM state encoding (IDLE, RUN, PAUSE)
//   MODE_ONESHOT   : mode value for a single count-up then stop
//   MODE_PERIODIC  : mode value for an auto-reloading count
package cpt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cpt_timer_ctrl_prescaler.sv
// cpt_prescaler -- mod-PRESC phase counter producing a one-cycle step tick.
// Only instantiated when CPT_TIMER_CTRL_PRESCALE_EN is defined.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the phase
//   enable : advance the phase this cycle (timer running and not stopping)
//   clear  : return the phase to 0 (start, abort, one-shot completion)
//   tick   : high on the enabled cycle where the phase is PRESC-1
module cpt_prescaler #(
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] phase;

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/cpt_timer_ctrl.sv
// cpt_timer_ctrl -- start/stop/pause count-up timer with one-shot and
// periodic modes.
// Optional feature: define CPT_TIMER_CTRL_PRESCALE_EN to divide the count
// rate by PRESC (2..256); otherwise every RUN cycle is a count step.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   start : start from IDLE, or resume from PAUSE
//   stop  : pause from RUN, or abort from PAUSE (wins over start)
//   mode  : 0 one-shot, 1 periodic; sampled on a start from IDLE
//   limit : terminal count; sampled on a start from IDLE
//   count : current count, registered
//   busy  : high in RUN and PAUSE
//   done  : registered one-cycle pulse after a terminal-count step
module cpt_timer_ctrl
  import cpt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRESC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] limit_q, limit_nxt;
  logic             mode_q, mode_nxt;
  logic             done_nxt;
  logic             run_en;
  logic             step;
  logic             presc_clr;

  // A stop in RUN freezes everything at that same edge, including the
  // prescaler phase.
  assign run_en = (state == RUN) && !stop;

`ifdef CPT_TIMER_CTRL_PRESCALE_EN
  cpt_prescaler #(
    .PRESC(PRESC)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (run_en),
    .clear  (presc_clr),
    .tick   (step)
  );
`else
  logic unused_presc;
  assign step         = run_en;
  assign unused_presc = presc_clr ^ (^PRESC);
`endif

  assign busy = (state == RUN) || (state == PAUSE);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit_q;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    presc_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          limit_nxt = limit;
          mode_nxt  = mode;
          count_nxt = '0;
          presc_clr = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (step) begin
          if (count == limit_q) begin
            done_nxt = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              count_nxt = '0;
            end else begin
              state_nxt = IDLE;
              presc_clr = 1'b1;
            end
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          count_nxt = '0;
          presc_clr = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      done    <= 1'b0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      count   <= count_nxt;
      done    <= done_nxt;
      limit_q <= limit_nxt;
      mode_q  <= mode_nxt;
    end
  end

endmodule

// File: doc/cpt_timer_ctrl.md
CPT_TIMER_CTRL -- requirements
Module: cpt_timer_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, counter and limit width in bits.
REQ-002 Parameter: PRESC, 4, clock cycles per count step when the prescaler is compiled in; legal range 2..256.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  start from IDLE, or resume from PAUSE.
REQ-006 Port: stop  input  1  pause from RUN, or abort from PAUSE.
REQ-007 Port: mode  input  1  0 = one-shot, 1 = periodic; sampled only on a start from IDLE.
REQ-008 Port: limit  input  WIDTH  terminal count; sampled only on a start from IDLE.
REQ-009 Port: count  output  WIDTH  current count value, registered.
REQ-010 Port: busy  output  1  high in RUN and PAUSE.
REQ-011 Port: done  output  1  registered one-cycle pulse at terminal count.

Function
REQ-012 FSM states are IDLE, RUN and PAUSE, held in a registered state variable.
REQ-013 IDLE with start=1 and stop=0: latch limit_q and mode_q, clear count to 0, and go to RUN.
REQ-014 RUN with stop=1: go to PAUSE and hold count; the stop takes effect at the same edge.
REQ-015 PAUSE with start=1 and stop=0: return to RUN; count resumes from the held value.
REQ-016 PAUSE with stop=1: go to IDLE and clear count to 0; no done pulse.
REQ-017 start and stop both high: stop wins in RUN and in PAUSE; in IDLE, neither acts.
REQ-018 In RUN, on each step edge with count != limit_q: count increments by 1.
REQ-019 In RUN, on a step edge with count == limit_q: done is 1 in the following cycle.
REQ-020 Terminal count in one-shot mode: go to IDLE, and count holds limit_q until the next start.
REQ-021 Terminal count in periodic mode: count becomes 0 and the state stays RUN.
REQ-022 Periodic period is (limit_q+1) steps.
REQ-023 limit_q = 0 means a done pulse on every step; count stays 0.
REQ-024 Count never exceeds limit_q; no modulo-2^WIDTH wrap occurs.
REQ-025 Changes to limit or mode while busy are ignored.
REQ-026 A stop that coincides with a terminal-count step: stop wins, no done pulse, count holds.
REQ-027 A start in IDLE while done=1 is legal and restarts normally.

Reset
REQ-028 reset=1 at a clock edge forces IDLE, count=0, done=0, busy=0, limit_q=0, mode_q=0 and prescaler=0.
REQ-029 Reset overrides start and stop, including in the middle of a run; there is no done pulse on reset.

Configuration
REQ-030 The prescaler feature is controlled by the macro CPT_TIMER_CTRL_PRESCALE_EN.
REQ-031 With CPT_TIMER_CTRL_PRESCALE_EN defined, a mod-PRESC prescaler runs only in RUN.
REQ-032 With the prescaler, a step edge is the edge where the prescaler equals PRESC-1.
REQ-033 With the prescaler, the prescaler holds in PAUSE and clears on a start from IDLE, on a stop-abort and on terminal count in one-shot mode.
REQ-034 Without CPT_TIMER_CTRL_PRESCALE_EN, every clock edge in RUN is a step edge, and PRESC is unused.

Structure
REQ-035 Package cpt_pkg holds the state enum typedef (IDLE, RUN, PAUSE) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
REQ-036 Sub-module cpt_prescaler (enable, clear, tick out) is instantiated only under the macro.
REQ-037 The count register and FSM are implemented in cpt_timer_ctrl itself.

Verification
REQ-038 Scenario (no prescaler): reset, limit=3, mode=0, start pulse -> count 0,1,2,3 on successive cycles; done high for one cycle, coincident with the first IDLE cycle; busy low afterwards; count holds 3.
REQ-039 Scenario: limit=2, mode=1, start -> count sequence 0,1,2,0,1,2,...; done pulses every 3 cycles; busy stays high.
REQ-040 Scenario: limit=10, one-shot, stop at count=4, hold 5 cycles, then start -> count holds 4 through PAUSE, resumes 5..10, single done pulse.
REQ-041 Scenario: in PAUSE, stop pulse -> IDLE, count=0, no done; a start and stop pulse on the same cycle in RUN -> PAUSE.
REQ-042 Scenario: limit=0, mode=1 -> done high every cycle and count constant at 0; assert reset mid-run -> next cycle IDLE, count=0, done=0.
REQ-043 Scenario (with CPT_TIMER_CTRL_PRESCALE_EN, PRESC=4, limit=2, periodic) -> count advances every 4 cycles; done period is 12 cycles; pausing freezes the prescaler phase.
